// File: rtl/jt1943_mister_inputs_if.sv
// Input/output bundle between the MiSTer front end (hps_io, OSD) and the
// player-input conditioning stage feeding jt1943_game.
interface jt1943_mister_inputs_if;
    logic [10:0] ps2_key;
    logic [15:0] joy_0;
    logic [15:0] joy_1;
    logic        autofire_en;
    logic [5:0]  joystick1;
    logic [5:0]  joystick2;
    logic [1:0]  start_button;
    logic [1:0]  coin_input;
    logic        dip_pause;
    logic        dip_test;

    modport master (
        output ps2_key, joy_0, joy_1, autofire_en,
        input  joystick1, joystick2, start_button, coin_input, dip_pause, dip_test
    );

    modport slave (
        input  ps2_key, joy_0, joy_1, autofire_en,
        output joystick1, joystick2, start_button, coin_input, dip_pause, dip_test
    );
endinterface

// File: rtl/jt1943_mister_inputs.sv
// Merges PS/2 keys and MiSTer pads into jt1943_game's active-low controls,
// with coin pulse shaping, pause toggle and optional autofire (JT1943_AUTOFIRE_EN).
module jt1943_mister_inputs #(
    parameter int unsigned COIN_CYCLES  = 1200000,
    parameter int unsigned AUTOFIRE_DIV = 400000
) (
    input  logic                  clk,
    input  logic                  rst,
    jt1943_mister_inputs_if.slave io
);
    localparam int K_RIGHT = 0;
    localparam int K_LEFT  = 1;
    localparam int K_DOWN  = 2;
    localparam int K_UP    = 3;
    localparam int K_FIRE  = 4;
    localparam int K_BOMB  = 5;
    localparam int K_S1    = 6;
    localparam int K_S2    = 7;
    localparam int K_COIN  = 8;
    localparam int K_PAUSE = 9;
    localparam int K_TEST  = 10;

    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_ACTIVE = 2'd1;
    localparam logic [1:0]  ST_HOLD   = 2'd2;
    localparam logic [23:0] COIN_LOAD = 24'(COIN_CYCLES);

    logic        prime_q;
    logic        tog_q;
    logic [10:0] key_q, key_d;
    logic [7:0]  joy0_q, joy1_q;
    logic [1:0]  coin_req_q, coin_req_d, coin_prev_q, coin_rise;
    logic        pause_req_q, pause_req_d, pause_prev_q, pause_rise;
    logic        paused_q, paused_d;
    logic [1:0]  coin_st_q  [2];
    logic [1:0]  coin_st_d  [2];
    logic [23:0] coin_cnt_q [2];
    logic [23:0] coin_cnt_d [2];
    logic [1:0]  fire_w, fire_out;
    logic [5:0]  joystick1_q, joystick2_q;
    logic [1:0]  start_q, coin_q;
    logic        dip_pause_q, dip_test_q;
    logic        unused_bits;

    assign unused_bits = ^{io.ps2_key[8], io.joy_0[15:10], io.joy_1[15:10]};

    // No event is taken on the priming cycle: tog_q only learns the current toggle level.
    always_comb begin
        key_d = key_q;
        if (prime_q && (io.ps2_key[10] != tog_q)) begin
            case (io.ps2_key[7:0])
                8'h75:        key_d[K_UP]    = io.ps2_key[9];
                8'h72:        key_d[K_DOWN]  = io.ps2_key[9];
                8'h6B:        key_d[K_LEFT]  = io.ps2_key[9];
                8'h74:        key_d[K_RIGHT] = io.ps2_key[9];
                8'h14, 8'h11: key_d[K_FIRE]  = io.ps2_key[9];
                8'h29:        key_d[K_BOMB]  = io.ps2_key[9];
                8'h05:        key_d[K_S1]    = io.ps2_key[9];
                8'h06:        key_d[K_S2]    = io.ps2_key[9];
                8'h04:        key_d[K_COIN]  = io.ps2_key[9];
                8'h0C:        key_d[K_PAUSE] = io.ps2_key[9];
                8'h03:        key_d[K_TEST]  = io.ps2_key[9];
                default: ;
            endcase
        end
    end

    assign coin_req_d  = {io.joy_1[8], key_d[K_COIN] | io.joy_0[8]};
    assign pause_req_d = key_d[K_PAUSE] | io.joy_0[9] | io.joy_1[9];
    assign coin_rise   = coin_req_q & ~coin_prev_q & {2{prime_q}};
    assign pause_rise  = pause_req_q & ~pause_prev_q & prime_q;
    assign paused_d    = paused_q ^ pause_rise;
    assign fire_w      = {key_q[K_FIRE] | joy1_q[4], key_q[K_FIRE] | joy0_q[4]};

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            coin_st_d[c]  = coin_st_q[c];
            coin_cnt_d[c] = coin_cnt_q[c];
            case (coin_st_q[c])
                ST_IDLE: begin
                    if (coin_rise[c]) begin
                        coin_st_d[c]  = ST_ACTIVE;
                        coin_cnt_d[c] = COIN_LOAD;
                    end
                end
                ST_ACTIVE: begin
                    if (coin_cnt_q[c] == 24'd1) begin
                        coin_st_d[c] = coin_req_q[c] ? ST_HOLD : ST_IDLE;
                    end else begin
                        coin_cnt_d[c] = coin_cnt_q[c] - 24'd1;
                    end
                end
                ST_HOLD: begin
                    if (!coin_req_q[c]) coin_st_d[c] = ST_IDLE;
                end
                default: coin_st_d[c] = ST_IDLE;
            endcase
        end
    end

`ifdef JT1943_AUTOFIRE_EN
    localparam logic [19:0] AF_LOAD = 20'(AUTOFIRE_DIV - 1);

    logic [19:0] af_cnt_q [2];
    logic [19:0] af_cnt_d [2];
    logic [1:0]  af_ph_q, af_ph_d, fire_prev_q;

    // A fresh press restarts the cadence with the shot phase so the first shot is immediate.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            af_cnt_d[p] = af_cnt_q[p];
            af_ph_d[p]  = af_ph_q[p];
            if (fire_w[p] && !fire_prev_q[p]) begin
                af_ph_d[p]  = 1'b1;
                af_cnt_d[p] = AF_LOAD;
            end else if (fire_w[p]) begin
                if (af_cnt_q[p] == 20'd0) begin
                    af_ph_d[p]  = ~af_ph_q[p];
                    af_cnt_d[p] = AF_LOAD;
                end else begin
                    af_cnt_d[p] = af_cnt_q[p] - 20'd1;
                end
            end
            fire_out[p] = fire_w[p] & (~io.autofire_en | af_ph_d[p]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            af_cnt_q[0] <= '0;
            af_cnt_q[1] <= '0;
            af_ph_q     <= '0;
            fire_prev_q <= '0;
        end else begin
            af_cnt_q[0] <= af_cnt_d[0];
            af_cnt_q[1] <= af_cnt_d[1];
            af_ph_q     <= af_ph_d;
            fire_prev_q <= fire_w;
        end
    end
`else
    logic unused_af;

    assign fire_out  = fire_w;
    assign unused_af = io.autofire_en;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prime_q       <= 1'b0;
            tog_q         <= 1'b0;
            key_q         <= '0;
            joy0_q        <= '0;
            joy1_q        <= '0;
            coin_req_q    <= '0;
            coin_prev_q   <= '0;
            pause_req_q   <= 1'b0;
            pause_prev_q  <= 1'b0;
            paused_q      <= 1'b0;
            coin_st_q[0]  <= ST_IDLE;
            coin_st_q[1]  <= ST_IDLE;
            coin_cnt_q[0] <= '0;
            coin_cnt_q[1] <= '0;
            joystick1_q   <= 6'h3F;
            joystick2_q   <= 6'h3F;
            start_q       <= 2'b11;
            coin_q        <= 2'b11;
            dip_pause_q   <= 1'b1;
            dip_test_q    <= 1'b1;
        end else begin
            prime_q      <= 1'b1;
            tog_q        <= io.ps2_key[10];
            key_q        <= key_d;
            joy0_q       <= io.joy_0[7:0];
            joy1_q       <= io.joy_1[7:0];
            coin_req_q   <= coin_req_d;
            pause_req_q  <= pause_req_d;
            // While priming, the edge history follows the fresh sample so a held request cannot fire.
            coin_prev_q  <= prime_q ? coin_req_q : coin_req_d;
            pause_prev_q <= prime_q ? pause_req_q : pause_req_d;
            paused_q     <= paused_d;
            for (int c = 0; c < 2; c++) begin
                coin_st_q[c]  <= coin_st_d[c];
                coin_cnt_q[c] <= coin_cnt_d[c];
                coin_q[c]     <= (coin_st_d[c] != ST_ACTIVE);
            end
            joystick1_q  <= ~{key_q[K_BOMB] | joy0_q[5], fire_out[0], key_q[3:0] | joy0_q[3:0]};
            joystick2_q  <= ~{key_q[K_BOMB] | joy1_q[5], fire_out[1], key_q[3:0] | joy1_q[3:0]};
            start_q      <= ~(key_q[K_S2:K_S1] | joy0_q[7:6] | joy1_q[7:6]);
            dip_pause_q  <= ~paused_d;
            dip_test_q   <= ~key_q[K_TEST];
        end
    end

    assign io.joystick1    = joystick1_q;
    assign io.joystick2    = joystick2_q;
    assign io.start_button = start_q;
    assign io.coin_input   = coin_q;
    assign io.dip_pause    = dip_pause_q;
    assign io.dip_test     = dip_test_q;
endmodule

// File: tb/tb_jt1943_mister_inputs.sv
// Bench for jt1943_mister_inputs: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model of the input rules.
module tb_jt1943_mister_inputs;
    localparam int COIN = 5;
    localparam int DIV  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    logic chk_en = 1'b0;

    jt1943_mister_inputs_if bus();

    jt1943_mister_inputs #(.COIN_CYCLES(COIN), .AUTOFIRE_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    always #5 clk = ~clk;

    // Model state: what the game should see, derived from the input rules.
    logic [10:0] mkb;
    logic        mtog, mprimed, mpaused;
    logic [15:0] mj0, mj1;
    logic [1:0]  mreq1, mreq2;
    logic        mpreq1, mpreq2;
    int          mleft [2];
    int          mt [2];
    logic [1:0]  mfprev;
    logic [5:0]  e_joy1, e_joy2;
    logic [1:0]  e_start, e_coin;
    logic        e_pause, e_test;

    logic [7:0] codes [12] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11,
                               8'h29, 8'h05, 8'h06, 8'h04, 8'h0C, 8'h03};

    function automatic int key_idx(input logic [7:0] c);
        case (c)
            8'h74: return 0;
            8'h6B: return 1;
            8'h72: return 2;
            8'h75: return 3;
            8'h14, 8'h11: return 4;
            8'h29: return 5;
            8'h05: return 6;
            8'h06: return 7;
            8'h04: return 8;
            8'h0C: return 9;
            8'h03: return 10;
            default: return -1;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mkb = '0; mtog = 1'b0; mprimed = 1'b0; mpaused = 1'b0;
        mj0 = '0; mj1 = '0; mreq1 = '0; mreq2 = '0; mpreq1 = 1'b0; mpreq2 = 1'b0;
        mleft[0] = 0; mleft[1] = 0; mt[0] = 0; mt[1] = 0; mfprev = '0;
        e_joy1 = 6'h3F; e_joy2 = 6'h3F; e_start = 2'b11; e_coin = 2'b11;
        e_pause = 1'b1; e_test = 1'b1;
    endtask

    task automatic model_step();
        logic [1:0] creq;
        logic       preq;
        logic       fire_now, shot;
        int         k;
        // Outputs of this edge reflect the key state and pad samples of the previous edge.
        e_joy1  = ~(mkb[5:0] | mj0[5:0]);
        e_joy2  = ~(mkb[5:0] | mj1[5:0]);
`ifdef JT1943_AUTOFIRE_EN
        for (int p = 0; p < 2; p++) begin
            fire_now = mkb[4] | (p == 0 ? mj0[4] : mj1[4]);
            if (fire_now && !mfprev[p]) mt[p] = 0;
            else if (fire_now) mt[p] = mt[p] + 1;
            shot = fire_now && (!bus.autofire_en || ((mt[p] / DIV) % 2 == 0));
            mfprev[p] = fire_now;
            if (p == 0) e_joy1[4] = ~shot;
            else        e_joy2[4] = ~shot;
        end
`endif
        e_start = ~(mkb[7:6] | mj0[7:6] | mj1[7:6]);
        e_test  = ~mkb[10];
        for (int c = 0; c < 2; c++) begin
            if (mleft[c] > 0) mleft[c] = mleft[c] - 1;
            else if (mreq1[c] && !mreq2[c]) mleft[c] = COIN;
            e_coin[c] = (mleft[c] == 0);
        end
        if (mpreq1 && !mpreq2) mpaused = ~mpaused;
        e_pause = ~mpaused;
        // Capture this edge's inputs.
        if (mprimed && (bus.ps2_key[10] != mtog)) begin
            k = key_idx(bus.ps2_key[7:0]);
            if (k >= 0) mkb[k] = bus.ps2_key[9];
        end
        mtog = bus.ps2_key[10];
        mj0  = bus.joy_0;
        mj1  = bus.joy_1;
        creq = {bus.joy_1[8], mkb[8] | bus.joy_0[8]};
        preq = mkb[9] | bus.joy_0[9] | bus.joy_1[9];
        mreq2  = mprimed ? mreq1 : creq;
        mpreq2 = mprimed ? mpreq1 : preq;
        mreq1  = creq;
        mpreq1 = preq;
        mprimed = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("joystick1",    8'(bus.joystick1),    8'(e_joy1));
            chk("joystick2",    8'(bus.joystick2),    8'(e_joy2));
            chk("start_button", 8'(bus.start_button), 8'(e_start));
            chk("coin_input",   8'(bus.coin_input),   8'(e_coin));
            chk("dip_pause",    8'(bus.dip_pause),    8'(e_pause));
            chk("dip_test",     8'(bus.dip_test),     8'(e_test));
        end
    end

    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset();
        else     model_step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        int first, lows, idx;
        logic [7:0] code;
        bus.ps2_key = 11'h7FF; bus.joy_0 = '1; bus.joy_1 = '1; bus.autofire_en = 1'b1;
        model_reset();
        #1 rst = 1'b1;
        repeat (3) cyc();
        chk_en = 1'b1;
        chk("rst_joystick1", 8'(bus.joystick1), 8'h3F);
        chk("rst_joystick2", 8'(bus.joystick2), 8'h3F);
        chk("rst_start",     8'(bus.start_button), 8'h03);
        chk("rst_coin",      8'(bus.coin_input), 8'h03);
        chk("rst_pause",     8'(bus.dip_pause), 8'h01);
        chk("rst_test",      8'(bus.dip_test), 8'h01);

        // Toggled "up pressed" present while priming must be ignored.
        bus.joy_0 = '0; bus.joy_1 = '0; bus.autofire_en = 1'b0; bus.ps2_key = 11'h675;
        rst = 1'b0;
        repeat (4) cyc();
        chk("prime_ignored", 8'(bus.joystick1), 8'h3F);

        bus.ps2_key = 11'h26B;
        cyc();
        chk("left_edge1", 8'(bus.joystick1), 8'h3F);
        cyc();
        chk("left_p1", 8'(bus.joystick1), 8'h3D);
        chk("left_p2", 8'(bus.joystick2), 8'h3D);
        bus.ps2_key = 11'h46B;
        cyc(); cyc();
        chk("left_rel_p1", 8'(bus.joystick1), 8'h3F);
        chk("left_rel_p2", 8'(bus.joystick2), 8'h3F);

        bus.joy_0[8] = 1'b1;
        first = -1; lows = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (!bus.coin_input[0]) begin
                if (first < 0) first = i;
                lows++;
            end
        end
        chk("coin_start", 8'(first), 8'd1);
        chk("coin_len_held", 8'(lows), 8'd5);
        bus.joy_0[8] = 1'b0;
        repeat (3) cyc();
        bus.joy_0[8] = 1'b1;
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (!bus.coin_input[0]) lows++;
        end
        chk("coin_repress", 8'(lows), 8'd5);
        bus.joy_0[8] = 1'b0;
        repeat (3) cyc();

        for (int n = 0; n < 3; n++) begin
            bus.joy_1[9] = 1'b1; cyc(); cyc();
            bus.joy_1[9] = 1'b0; repeat (3) cyc();
            chk("pause_toggle", 8'(bus.dip_pause), (n % 2 == 0) ? 8'h00 : 8'h01);
        end

        bus.joy_0[8] = 1'b1;
        cyc(); cyc(); cyc();
        chk("coin_midpulse", 8'(bus.coin_input), 8'h02);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("rst_async_coin",  8'(bus.coin_input), 8'h03);
        chk("rst_async_pause", 8'(bus.dip_pause), 8'h01);
        cyc();
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (!bus.coin_input[0]) lows++;
        end
        chk("coin_held_after_rst", 8'(lows), 8'd0);
        bus.joy_0[8] = 1'b0;
        repeat (3) cyc();

`ifdef JT1943_AUTOFIRE_EN
        bus.autofire_en = 1'b1; bus.joy_0[4] = 1'b1;
        for (int i = 0; i < 13; i++) begin
            cyc();
            if (i >= 1) chk("autofire_on", 8'(bus.joystick1[4]), 8'(((i - 1) / 3) % 2));
        end
        bus.joy_0[4] = 1'b0; cyc(); cyc();
        bus.autofire_en = 1'b0; bus.joy_0[4] = 1'b1;
        for (int i = 0; i < 13; i++) begin
            cyc();
            if (i >= 1) chk("autofire_off", 8'(bus.joystick1[4]), 8'd0);
        end
        bus.joy_0[4] = 1'b0; cyc(); cyc();
`endif

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                code = ($urandom_range(0, 3) == 0) ? 8'($urandom) : codes[$urandom_range(0, 11)];
                bus.ps2_key = {~bus.ps2_key[10], 1'($urandom), 1'($urandom), code};
            end
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, 15);
                bus.joy_0[idx] = ~bus.joy_0[idx];
            end
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, 15);
                bus.joy_1[idx] = ~bus.joy_1[idx];
            end
            if ($urandom_range(0, 63) == 0) bus.autofire_en = ~bus.autofire_en;
            if (rst) begin
                #2 rst = 1'b0;
            end else if ($urandom_range(0, 499) == 0) begin
                #2 rst = 1'b1;
                model_reset();
            end
            cyc();
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
